qspi_reg_bridge: RTL and testbench

- Sits downstream of the QSPI slave receiver and upstream of the QSPI slave transmitter, in the main clk domain.
- Decodes received byte streams into register-file writes and read requests.
- Supplies transmit bytes, fetched from the register file, for the following read transaction.
- Owns the read/write turnaround: asserts tx_en, which the top level uses as the QD tri-state enable.

---
 rtl/qspi_reg_bridge_pkg.sv | 22 ++
 rtl/qspi_reg_bridge.sv | 176 +++++++++++++++++
 tb/tb_qspi_reg_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_reg_bridge_pkg.sv
// Shared definitions for the QSPI register bridge.
//   CMD_READ_BIT : bit of the command byte that selects a read transaction
//   state_t      : bridge FSM state encoding (StIdle .. StTx)
//   is_read_cmd  : decodes the R bit of a command byte
package qspi_reg_bridge_pkg;

   localparam int unsigned CMD_READ_BIT = 7;

   typedef logic [2:0] state_t;

   localparam state_t StIdle   = 3'd0;
   localparam state_t StWrite  = 3'd1;
   localparam state_t StArmed  = 3'd2;
   localparam state_t StFetch0 = 3'd3;
   localparam state_t StFetch1 = 3'd4;
   localparam state_t StTx     = 3'd5;

   function automatic logic is_read_cmd(input logic [7:0] cmd);
      return cmd[CMD_READ_BIT];
   endfunction

endpackage

// File: rtl/qspi_reg_bridge.sv
// QSPI register bridge: turns received byte streams into register-file writes,
// and prefetches register bytes for the transmitter on read transactions.
//   clk, reset       : system clock, synchronous active-high reset
//   rxdata, rxready  : received byte and its one-clk valid pulse
//   deselect         : one-clk pulse at the end of a QSPI transaction
//   txdata, txready  : byte offered to the transmitter, consumed-pulse back
//   tx_en            : QD tri-state enable (slave is transmitting)
//   reg_addr         : register address for reg_we / reg_re
//   reg_wdata,reg_we : write data and one-clk write strobe
//   reg_re,reg_rdata : one-clk read strobe, data returned one clk later
//   err              : one-clk pulse on bytes received during a read transaction
module qspi_reg_bridge
   import qspi_reg_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rxdata,
   input  logic              rxready,
   input  logic              deselect,
   output logic [7:0]        txdata,
   input  logic              txready,
   output logic              tx_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              err
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        txdata_q, txdata_d;
   logic              tx_en_q, tx_en_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   // Set in the clk after a read strobe: reg_rdata is valid and lands in txdata.
   logic              pend_q, pend_d;
   logic              rd_issue;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      txdata_d  = txdata_q;
      tx_en_d   = tx_en_q;
      we_d      = 1'b0;
      err_d     = 1'b0;
      rd_issue  = 1'b0;

      // An in-flight fetch always completes, whatever the state has become.
      if (pend_q) begin
         txdata_d = reg_rdata;
      end

      unique case (state_q)
         StIdle: begin
            if (rxready) begin
               addr_d = rxdata[ADDR_W-1:0];
               if (is_read_cmd(rxdata)) begin
                  if (deselect) begin
                     state_d = StFetch0;
                     tx_en_d = 1'b1;
                  end else begin
                     state_d = StArmed;
                  end
               end else if (!deselect) begin
                  state_d = StWrite;
               end
            end
         end

         StWrite: begin
            if (rxready) begin
               we_d      = 1'b1;
               wdata_d   = rxdata;
               wr_addr_d = addr_q;
               addr_d    = addr_q + ADDR_W'(1);
            end
            if (deselect) begin
               state_d = StIdle;
            end
         end

         StArmed: begin
            if (rxready) begin
               err_d = 1'b1;
            end
            if (deselect) begin
               state_d = StFetch0;
               tx_en_d = 1'b1;
            end
         end

         StFetch0: begin
            if (rxready) begin
               err_d = 1'b1;
            end
            rd_issue = 1'b1;
            state_d  = StFetch1;
         end

         StFetch1: begin
            if (rxready) begin
               err_d = 1'b1;
            end
            state_d = StTx;
         end

         StTx: begin
            if (rxready) begin
               err_d = 1'b1;
            end
            // Deselect wins over a coincident txready: no fetch is started.
            if (deselect) begin
               tx_en_d = 1'b0;
               state_d = StIdle;
            end else if (txready) begin
               rd_issue = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
            tx_en_d = 1'b0;
         end
      endcase

      // Address advances when the read is issued, so back-to-back fetches
      // never reuse an address.
      if (rd_issue) begin
         addr_d = addr_q + ADDR_W'(1);
      end
      pend_d = rd_issue;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wr_addr_q <= '0;
         wdata_q   <= 8'h00;
         txdata_q  <= 8'h00;
         tx_en_q   <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         txdata_q  <= txdata_d;
         tx_en_q   <= tx_en_d;
         we_q      <= we_d;
         err_q     <= err_d;
         pend_q    <= pend_d;
      end
   end

   // Read strobe is combinational so a fetch lands in txdata 2 clk after
   // txready; both strobes are masked while reset is held.
   assign reg_re    = rd_issue & ~reset;
   assign reg_we    = we_q & ~reset;
   assign reg_addr  = rd_issue ? addr_q : wr_addr_q;
   assign reg_wdata = wdata_q;
   assign txdata    = txdata_q;
   assign tx_en     = tx_en_q;
   assign err       = err_q;

endmodule

// File: tb/tb_qspi_reg_bridge.sv
module tb_qspi_reg_bridge;
   import qspi_reg_bridge_pkg::*;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rxdata = 8'h00;
   logic          rxready = 1'b0;
   logic          deselect = 1'b0;
   logic [7:0]    txdata;
   logic          txready = 1'b0;
   logic          tx_en;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wdata;
   logic          reg_we;
   logic          reg_re;
   logic [7:0]    reg_rdata;
   logic          err;

   qspi_reg_bridge #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .rxdata    (rxdata),
      .rxready   (rxready),
      .deselect  (deselect),
      .txdata    (txdata),
      .txready   (txready),
      .tx_en     (tx_en),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Register file model: synchronous write, read data one clk after reg_re.
   logic [7:0] regs [16];
   always @(posedge clk) begin
      if (reg_we) regs[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= regs[reg_addr];
   end

   int we_cnt = 0, re_cnt = 0, err_cnt = 0, both_cnt = 0;
   always @(posedge clk) begin
      if (!reset) begin
         if (reg_we) we_cnt <= we_cnt + 1;
         if (reg_re) re_cnt <= re_cnt + 1;
         if (err) err_cnt <= err_cnt + 1;
         if (reg_we && reg_re) both_cnt <= both_cnt + 1;
      end
   end

   int n_checks = 0;
   int n_fail = 0;
   int snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rxdata  = b;
      rxready = 1'b1;
      step();
      rxready = 1'b0;
   endtask

   task automatic desel();
      deselect = 1'b1;
      step();
      deselect = 1'b0;
   endtask

   task automatic tx_pulse();
      txready = 1'b1;
      step();
      txready = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_tx_en", 32'(tx_en), 32'h0);
      check("rst_txdata", 32'(txdata), 32'h00);
      check("rst_we", 32'(reg_we), 32'h0);
      check("rst_re", 32'(reg_re), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_addr", 32'(reg_addr), 32'h0);
      check("rst_wdata", 32'(reg_wdata), 32'h00);
      check("rst_state", 32'(dut.state_q), 32'(StIdle));
      reset = 1'b0;
      step();

      // Write burst at 3,4,5
      rx_byte(8'h03);
      check("wr_state", 32'(dut.state_q), 32'(StWrite));
      rx_byte(8'hA1);
      check("wr1_we", 32'(reg_we), 32'h1);
      check("wr1_addr", 32'(reg_addr), 32'h3);
      check("wr1_data", 32'(reg_wdata), 32'hA1);
      rx_byte(8'hB2);
      check("wr2_addr", 32'(reg_addr), 32'h4);
      check("wr2_data", 32'(reg_wdata), 32'hB2);
      rx_byte(8'hC3);
      check("wr3_addr", 32'(reg_addr), 32'h5);
      check("wr3_data", 32'(reg_wdata), 32'hC3);
      desel();
      check("wr_tx_en", 32'(tx_en), 32'h0);
      check("wr_idle", 32'(dut.state_q), 32'(StIdle));
      check("wr_cnt", 32'(we_cnt), 32'd3);
      check("wr_reg5", 32'(regs[5]), 32'hC3);

      // Preset regs 1..4; last byte coincides with deselect
      rx_byte(8'h01);
      rx_byte(8'h9C);
      rx_byte(8'h11);
      rx_byte(8'h22);
      rxdata   = 8'h33;
      rxready  = 1'b1;
      deselect = 1'b1;
      step();
      rxready  = 1'b0;
      deselect = 1'b0;
      check("wrds_we", 32'(reg_we), 32'h1);
      check("wrds_addr", 32'(reg_addr), 32'h4);
      check("wrds_data", 32'(reg_wdata), 32'h33);
      check("wrds_idle", 32'(dut.state_q), 32'(StIdle));
      step();
      check("wrds_reg4", 32'(regs[4]), 32'h33);

      // Read burst from 2
      rx_byte(8'h82);
      check("rd_armed", 32'(dut.state_q), 32'(StArmed));
      check("rd_armed_txen", 32'(tx_en), 32'h0);
      desel();
      check("rd_fetch0", 32'(dut.state_q), 32'(StFetch0));
      check("rd_f0_re", 32'(reg_re), 32'h1);
      check("rd_f0_addr", 32'(reg_addr), 32'h2);
      check("rd_tx_en", 32'(tx_en), 32'h1);
      step();
      step();
      check("rd_tx0", 32'(txdata), 32'h11);
      check("rd_state_tx", 32'(dut.state_q), 32'(StTx));
      txready = 1'b1;
      #1;
      check("rd_tx_re", 32'(reg_re), 32'h1);
      check("rd_tx_re_addr", 32'(reg_addr), 32'h3);
      step();
      txready = 1'b0;
      check("rd_tx_hold", 32'(txdata), 32'h11);
      step();
      check("rd_tx1", 32'(txdata), 32'h22);
      tx_pulse();
      step();
      check("rd_tx2", 32'(txdata), 32'h33);
      desel();
      check("rd_end_txen", 32'(tx_en), 32'h0);
      check("rd_end_idle", 32'(dut.state_q), 32'(StIdle));

      // Address wrap on writes and reads
      rx_byte(8'h0F);
      rx_byte(8'h5A);
      check("wrap_w1_addr", 32'(reg_addr), 32'hF);
      check("wrap_w1_data", 32'(reg_wdata), 32'h5A);
      rx_byte(8'h6B);
      check("wrap_w2_addr", 32'(reg_addr), 32'h0);
      check("wrap_w2_data", 32'(reg_wdata), 32'h6B);
      desel();
      check("wrap_reg15", 32'(regs[15]), 32'h5A);
      check("wrap_reg0", 32'(regs[0]), 32'h6B);
      rx_byte(8'h8F);
      desel();
      step();
      step();
      check("wrap_rd0", 32'(txdata), 32'h5A);
      tx_pulse();
      step();
      check("wrap_rd1", 32'(txdata), 32'h6B);
      desel();

      // Read command coincident with deselect, then txready with deselect
      rxdata   = 8'h84;
      rxready  = 1'b1;
      deselect = 1'b1;
      step();
      rxready  = 1'b0;
      deselect = 1'b0;
      check("sim_fetch0", 32'(dut.state_q), 32'(StFetch0));
      check("sim_f0_addr", 32'(reg_addr), 32'h4);
      step();
      step();
      check("sim_tx0", 32'(txdata), 32'h33);
      snap     = re_cnt;
      txready  = 1'b1;
      deselect = 1'b1;
      #1;
      check("sim_no_re", 32'(reg_re), 32'h0);
      step();
      txready  = 1'b0;
      deselect = 1'b0;
      check("sim_txen", 32'(tx_en), 32'h0);
      check("sim_idle", 32'(dut.state_q), 32'(StIdle));
      step();
      check("sim_re_cnt", 32'(re_cnt), 32'(snap));
      check("sim_txdata", 32'(txdata), 32'h33);

      // Extra byte during a read transaction
      snap = we_cnt;
      rx_byte(8'h81);
      rx_byte(8'hFF);
      check("err_pulse", 32'(err), 32'h1);
      step();
      check("err_low", 32'(err), 32'h0);
      check("err_once", 32'(err_cnt), 32'd1);
      desel();
      step();
      step();
      check("err_rd", 32'(txdata), 32'h9C);
      check("err_no_we", 32'(we_cnt), 32'(snap));
      desel();

      // Reset in the middle of a transmit
      rx_byte(8'h82);
      desel();
      step();
      step();
      check("rst_pre_tx", 32'(txdata), 32'h11);
      reset = 1'b1;
      #1;
      check("rst_cycle_re", 32'(reg_re), 32'h0);
      step();
      check("rst_tx_txen", 32'(tx_en), 32'h0);
      check("rst_tx_data", 32'(txdata), 32'h00);
      check("rst_tx_idle", 32'(dut.state_q), 32'(StIdle));
      reset = 1'b0;
      rx_byte(8'h01);
      rx_byte(8'h77);
      check("post_rst_addr", 32'(reg_addr), 32'h1);
      check("post_rst_data", 32'(reg_wdata), 32'h77);
      desel();
      check("post_rst_reg1", 32'(regs[1]), 32'h77);

      check("no_we_re_overlap", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
